three_bit_1x4_route: RTL
========================

# three_bit_1x4_route

Single-entry-per-lane router that takes a 3-bit value (FPU stack index or tag code) with a 2-bit destination select over a valid/ready handshake. It delivers the value into one of four registered output lanes, each with its own valid/ack handshake. It sits on the FPU8087 microsequencer side as the fan-out counterpart to the 4:1 operand-index selectors: one producer distributes register indices to four consumers (operand A, operand B, writeback, tag update). It provides per-lane backpressure, a synchronous flush and a sticky protocol-error flag.

## Interface
- WIDTH, 3, data width of value and every lane; the only legal value in FPU8087 is 3, other values are untested.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  value to route.
- in_select  in  2  destination lane, 0..3.
- in_valid  in  1  producer offers in_data/in_select.
- in_ready  out  1  router can accept this cycle (combinational).
- flush  in  1  synchronous clear of all lanes and the error flag.
- out0, out1, out2, out3  out  WIDTH  lane data registers.
- out_valid  out  4  bit n means outn holds an unconsumed value.
- out_ack  in  4  bit n means consumer n takes outn this cycle.
- ack_err  out  1  sticky: an ack arrived on a lane whose valid was 0.

## Operation
- Lane n is free when out_valid[n]=0, or when out_valid[n]=1 and out_ack[n]=1 in the same cycle (pass-through reload).
- in_ready = !flush & (lane in_select is free). It depends combinationally on in_select, out_valid and out_ack, and never on in_valid.
- Accept = in_valid & in_ready. On accept, at the next edge: out[in_select] <= in_data and out_valid[in_select] <= 1.
- Ack on a valid lane n with no accept to n: out_valid[n] <= 0. outn keeps its last value; data is not cleared.
- Ack and accept to the same lane in one cycle: the new data loads and valid stays 1. This sustains one transfer per cycle per lane.
- Acks and accepts to different lanes are independent. Any mix of out_ack bits may be asserted together.
- out_ack[n]=1 while out_valid[n]=0 sets ack_err <= 1 at the next edge. Nothing else changes for that lane. ack_err clears only on flush or reset.
- in_valid=0 means in_data/in_select are don't-care. No state change results from them.
- flush=1: at the next edge all out_valid <= 0 and ack_err <= 0. Lane data is retained. in_ready=0 during flush, so no accept is possible. Acks during flush are ignored and do not set ack_err.
- Out-of-range select is impossible (2-bit). All 4 codes map to lanes 0..3 directly.

## Timing
- Reset (reset_n=0, asynchronous): out0..out3=0, out_valid=4'b0000, ack_err=0. in_ready follows combinationally (1 if flush=0).
- Reset deassertion needs no synchronizer inside this block. The top-level supplies a synchronously released reset_n.
- Latency: accept at edge k puts data visible on outn with out_valid[n]=1 after edge k. This is one cycle from in_valid/in_ready to out_valid.
- Throughput: one accept per cycle total; per lane, one per cycle when the consumer acks continuously.
- Reset mid-operation: all pending lane values are discarded immediately. The producer must re-offer after reset.
- Data and valid are registered outputs with no combinational path from in_data to outN. The only combinational path is out_ack/in_select/flush to in_ready.

## Test plan
- Reset and basic route: reset_n low then high, flush=0 -> outs 0, out_valid 0000, in_ready 1. Offer in_data=3'd5, sel=2 -> next cycle out2=5, out_valid=0100.
- Backpressure: lane 2 holds 5 unacked, offer data=3'd1, sel=2 -> in_ready=0 and out2 stays 5. Same cycle offer sel=0 instead -> accepted, out0=1, out_valid=0101.
- Pass-through reload: out_valid[1]=1 with out1=3. Assert out_ack=0010 plus offer data=6, sel=1 -> in_ready=1, next cycle out1=6, out_valid[1]=1. Back-to-back 4 cycles -> 4 values 0,7,2,4 stream with no bubble.
- Ack-only: out_valid=1111, out_ack=1010 -> next cycle out_valid=0101, out1/out3 data unchanged.
- Protocol error and flush: out_valid=0000, out_ack=0001 -> ack_err=1 next cycle and stays 1. Then flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0000, ack_err=0, lane data unchanged.
- Async reset mid-stream: out_valid=1011 and ack_err=1, pulse reset_n low between edges -> all outputs return to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/three_bit_1x4_route.sv
// 1:4 router: one 3-bit producer fans out to four registered lanes, each with
// its own valid/ack handshake, plus a flush and a sticky ack protocol-error flag.
module three_bit_1x4_route #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_select,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic             ack_err
);

    logic [WIDTH-1:0] lane_data [4];
    logic [3:0]       lane_valid;
    logic             err;
    logic [3:0]       lane_free;
    logic             accept;

    // A lane being acked this cycle can be reloaded in the same cycle.
    always_comb begin
        lane_free = ~lane_valid | out_ack;
        in_ready  = ~flush & lane_free[in_select];
        accept    = in_valid & in_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned n = 0; n < 4; n++) begin
                lane_data[n] <= '0;
            end
            lane_valid <= '0;
            err        <= 1'b0;
        end else if (flush) begin
            lane_valid <= '0;
            err        <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (accept && (in_select == 2'(n))) begin
                    lane_data[n]  <= in_data;
                    lane_valid[n] <= 1'b1;
                end else if (out_ack[n]) begin
                    lane_valid[n] <= 1'b0;
                end
            end
            err <= err | (|(out_ack & ~lane_valid));
        end
    end

    assign out0      = lane_data[0];
    assign out1      = lane_data[1];
    assign out2      = lane_data[2];
    assign out3      = lane_data[3];
    assign out_valid = lane_valid;
    assign ack_err   = err;

endmodule
